pll_reset_sequencer: RTL and testbench

- Sequences the iCE40 SB_PLL40_CORE 16 MHz PLL wrapper and is the stage directly downstream of its LOCK output.
- Runs on the free-running 16 MHz board oscillator, which is the same net that feeds the PLL REFERENCECLK.
- Drives the PLL's active-low RESETB.
- Debounces LOCK and releases an active-high system reset for logic clocked by PLLOUTGLOBAL only after lock is stable. Re-sequences on lock loss or lock timeout.

---
 rtl/pll_reset_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// ============================================================================
// Module   : pll_reset_sequencer
// Brief    : Holds SB_PLL40_CORE in reset, waits for a debounced LOCK, then
//            releases an active-high system reset; re-sequences on lock loss,
//            lock timeout or restart. Optional macro PLL_RESET_SEQ_LOSS_COUNT_EN
//            adds the lock_loss_count output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES     = 16,
  parameter int LOCK_TIMEOUT       = 65535,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES        = 7,
  parameter int CNT_W              = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       restart,
  output logic       pll_resetb,
  output logic       sys_reset,
  output logic       ready,
  output logic       fail,
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
  output logic [7:0] lock_loss_count,
`endif
  output logic [7:0] retry_count
);

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] C_RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] C_STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       retry_q, retry_d;
  logic             lock_meta_q, lock_meta_d;
  logic             lock_s_q, lock_s_d;
  logic             pll_resetb_q, pll_resetb_d;
  logic             sys_reset_q, sys_reset_d;
  logic             ready_q, ready_d;
  logic             fail_q, fail_d;
  logic [7:0]       retry_inc;
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
  logic [7:0]       loss_q, loss_d;
`endif

  assign retry_inc = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_PLL_RST;
      cnt_q        <= '0;
      retry_q      <= '0;
      lock_meta_q  <= 1'b0;
      lock_s_q     <= 1'b0;
      pll_resetb_q <= 1'b0;
      sys_reset_q  <= 1'b1;
      ready_q      <= 1'b0;
      fail_q       <= 1'b0;
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
      loss_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      lock_meta_q  <= lock_meta_d;
      lock_s_q     <= lock_s_d;
      pll_resetb_q <= pll_resetb_d;
      sys_reset_q  <= sys_reset_d;
      ready_q      <= ready_d;
      fail_q       <= fail_d;
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
      loss_q       <= loss_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    retry_d     = retry_q;
    lock_meta_d = pll_lock;
    lock_s_d    = lock_meta_q;
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
    loss_d      = loss_q;
`endif

    if (restart) begin
      state_d = ST_PLL_RST;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_PLL_RST: begin
          if (cnt_q == C_RST_LAST) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          // A lock seen on the timeout cycle still wins over the retry.
          if (lock_s_q) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == C_TIMEOUT_LAST) begin
            retry_d = retry_inc;
            cnt_d   = '0;
            if ((MAX_RETRIES != 0) && (int'({24'd0, retry_inc}) >= MAX_RETRIES)) begin
              state_d = ST_FAIL;
            end else begin
              state_d = ST_PLL_RST;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_STABLE: begin
          if (!lock_s_q) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == C_STABLE_LAST) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (!lock_s_q) begin
            state_d = ST_PLL_RST;
            cnt_d   = '0;
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
            loss_d  = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
`endif
          end
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d = ST_PLL_RST;
          cnt_d   = '0;
        end
      endcase
    end

    // Outputs lag the state register by one cycle; unknown encodings decode as reset.
    pll_resetb_d = 1'b0;
    sys_reset_d  = 1'b1;
    ready_d      = 1'b0;
    fail_d       = 1'b0;
    case (state_q)
      ST_WAIT_LOCK, ST_STABLE: pll_resetb_d = 1'b1;
      ST_RUN: begin
        pll_resetb_d = 1'b1;
        sys_reset_d  = 1'b0;
        ready_d      = 1'b1;
      end
      ST_FAIL: fail_d = 1'b1;
      default: ;
    endcase
  end

  assign pll_resetb  = pll_resetb_q;
  assign sys_reset   = sys_reset_q;
  assign ready       = ready_q;
  assign fail        = fail_q;
  assign retry_count = retry_q;
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
  assign lock_loss_count = loss_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
// ============================================================================
// Module   : tb_pll_reset_sequencer
// Brief    : Scoreboard bench for pll_reset_sequencer against a phase/countdown
//            reference model; honours PLL_RESET_SEQ_LOSS_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pll_reset_sequencer;

  localparam int C_RST  = 4;
  localparam int C_TMO  = 20;
  localparam int C_STB  = 8;
  localparam int C_MAXR = 3;

  localparam int PH_HOLD   = 0;
  localparam int PH_SEEK   = 1;
  localparam int PH_SETTLE = 2;
  localparam int PH_LIVE   = 3;
  localparam int PH_DEAD   = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       pll_lock;
  logic       restart;
  logic       pll_resetb;
  logic       sys_reset;
  logic       ready;
  logic       fail;
  logic [7:0] retry_count;
  logic [7:0] loss_act;
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
  logic [7:0] lock_loss_count;
  assign loss_act = lock_loss_count;
`else
  assign loss_act = 8'd0;
`endif

  pll_reset_sequencer #(
    .PLL_RST_CYCLES    (C_RST),
    .LOCK_TIMEOUT      (C_TMO),
    .LOCK_STABLE_CYCLES(C_STB),
    .MAX_RETRIES       (C_MAXR),
    .CNT_W             (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pll_lock   (pll_lock),
    .restart    (restart),
    .pll_resetb (pll_resetb),
    .sys_reset  (sys_reset),
    .ready      (ready),
    .fail       (fail),
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
    .lock_loss_count(lock_loss_count),
`endif
    .retry_count(retry_count)
  );

  always #10 clk = ~clk;

  int tests  = 0;
  int errors = 0;
  int cycle_no = 0;
  logic [19:0] exp_q[$];

  // Reference model: phase plus cycles remaining in it, plus raw-lock history.
  int m_phase, m_left, m_fails, m_losses;
  bit m_s1, m_s2;

  task automatic model_step(input bit r, input bit l, input bit rs);
    bit e_rb, e_sr, e_rdy, e_fl;
    if (r) begin
      m_phase = PH_HOLD; m_left = C_RST; m_fails = 0; m_losses = 0;
      m_s1 = 0; m_s2 = 0;
      e_rb = 0; e_sr = 1; e_rdy = 0; e_fl = 0;
    end else begin
      e_rb  = (m_phase == PH_SEEK) || (m_phase == PH_SETTLE) || (m_phase == PH_LIVE);
      e_sr  = (m_phase != PH_LIVE);
      e_rdy = (m_phase == PH_LIVE);
      e_fl  = (m_phase == PH_DEAD);
      if (rs) begin
        m_phase = PH_HOLD; m_left = C_RST; m_fails = 0;
      end else if (m_phase == PH_HOLD) begin
        m_left--;
        if (m_left == 0) begin m_phase = PH_SEEK; m_left = C_TMO; end
      end else if (m_phase == PH_SEEK) begin
        if (m_s2) begin
          m_phase = PH_SETTLE; m_left = C_STB;
        end else begin
          m_left--;
          if (m_left == 0) begin
            if (m_fails < 255) m_fails++;
            if (C_MAXR != 0 && m_fails >= C_MAXR) m_phase = PH_DEAD;
            else begin m_phase = PH_HOLD; m_left = C_RST; end
          end
        end
      end else if (m_phase == PH_SETTLE) begin
        if (!m_s2) begin
          m_phase = PH_SEEK; m_left = C_TMO;
        end else begin
          m_left--;
          if (m_left == 0) m_phase = PH_LIVE;
        end
      end else if (m_phase == PH_LIVE) begin
        if (!m_s2) begin
          m_phase = PH_HOLD; m_left = C_RST;
          if (m_losses < 255) m_losses++;
        end
      end
      m_s2 = m_s1;
      m_s1 = l;
    end
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
    exp_q.push_back({e_rb, e_sr, e_rdy, e_fl, 8'(m_fails), 8'(m_losses)});
`else
    exp_q.push_back({e_rb, e_sr, e_rdy, e_fl, 8'(m_fails), 8'd0});
`endif
  endtask

  task automatic drive(input bit r, input bit l, input bit rs);
    @(negedge clk);
    reset = r; pll_lock = l; restart = rs;
    model_step(r, l, rs);
  endtask

  task automatic hold(input bit l, input int n);
    for (int k = 0; k < n; k++) drive(1'b0, l, 1'b0);
  endtask

  // Reset asserted between edges must take effect without a clock edge.
  task automatic async_reset_check();
    @(posedge clk);
    #5;
    reset = 1'b1;
    #1;
    tests++;
    if ({pll_resetb, sys_reset, ready, fail} !== 4'b0100) begin
      errors++;
      $display("FAIL async_reset: got resetb=%b sys=%b rdy=%b fail=%b, exp resetb=0 sys=1 rdy=0 fail=0",
               pll_resetb, sys_reset, ready, fail);
    end
    drive(1'b1, pll_lock, 1'b0);
    drive(1'b1, pll_lock, 1'b0);
  endtask

  // Monitor: outputs are presented every cycle; compare after each edge.
  initial begin
    logic [19:0] exp_v, act_v;
    forever begin
      @(posedge clk);
      #2;
      cycle_no++;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act_v = {pll_resetb, sys_reset, ready, fail, retry_count, loss_act};
        tests++;
        if (act_v !== exp_v) begin
          errors++;
          $display("FAIL outputs cyc%0d: got resetb=%b sys=%b rdy=%b fail=%b retry=%0d loss=%0d, exp resetb=%b sys=%b rdy=%b fail=%b retry=%0d loss=%0d",
                   cycle_no, act_v[19], act_v[18], act_v[17], act_v[16], act_v[15:8], act_v[7:0],
                   exp_v[19], exp_v[18], exp_v[17], exp_v[16], exp_v[15:8], exp_v[7:0]);
        end
      end
    end
  end

  initial begin
    int run_left;
    bit cur_lock;
    bit rs_v, r_v;
    reset = 1'b1; pll_lock = 1'b0; restart = 1'b0;
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 1'b0);

    // Clean bring-up, lock 10 cycles after resetb rises.
    hold(1'b0, C_RST + 10);
    hold(1'b1, 30);
    // Lock loss in RUN and relock.
    hold(1'b0, 3);
    hold(1'b1, 40);
    // Short drop while settling, then full fresh settle.
    hold(1'b0, 1);
    hold(1'b1, 10);
    hold(1'b0, 3);
    hold(1'b1, 30);
    // Asynchronous reset mid-period while running.
    async_reset_check();
    // No lock at all: three attempts then FAIL.
    hold(1'b0, 90);
    // Restart out of FAIL, then restart mid-settle.
    drive(1'b0, 1'b0, 1'b1);
    hold(1'b1, 10);
    drive(1'b0, 1'b1, 1'b1);
    hold(1'b1, 30);

    // Randomized lock waveforms with occasional restart and reset.
    run_left = 0;
    cur_lock = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (run_left == 0) begin
        cur_lock = ~cur_lock;
        run_left = ($urandom_range(0, 9) == 0) ? 100 : $urandom_range(1, 40);
      end
      run_left--;
      rs_v = ($urandom_range(0, 149) == 0);
      r_v  = ($urandom_range(0, 599) == 0);
      drive(r_v, cur_lock, rs_v);
    end
    async_reset_check();
    hold(1'b1, 30);

    @(posedge clk);
    #4;
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

`default_nettype wire
